// File: rtl/power_sequencer.sv
// Power-up enable sequencer: staggers N_STAGES block enables after sys_ready.
// Ports: slow_clock, reset, sys_ready, lock_10 in; stage_en, seq_done, fault, fault_count out.
module power_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DELAY = 1000,
  parameter int LOCK_FILT   = 4,
  parameter int HOLDOFF     = 10000
) (
  input  logic                slow_clock,
  input  logic                reset,
  input  logic                sys_ready,
  input  logic                lock_10,
  output logic [N_STAGES-1:0] stage_en,
  output logic                seq_done,
  output logic                fault,
  output logic [7:0]          fault_count
);

  localparam int DW = $clog2(STAGE_DELAY + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int LW = $clog2(LOCK_FILT + 1);

  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DELAY - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]          state;
  logic [DW-1:0]       dly_cnt;
  logic [HW-1:0]       hold_cnt;
  logic [LW-1:0]       lock_cnt;
  logic [N_STAGES:0]   shifted;
  logic [N_STAGES-1:0] stage_next;
  logic                trip;

  // Next enable pattern fills in one more bit from the bottom.
  always_comb begin
    shifted    = {stage_en, 1'b1};
    stage_next = shifted[N_STAGES-1:0];
    trip       = !lock_10 && (lock_cnt == LOCK_LAST);
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state       <= S_IDLE;
      stage_en    <= '0;
      seq_done    <= 1'b0;
      fault       <= 1'b0;
      fault_count <= '0;
      dly_cnt     <= '0;
      hold_cnt    <= '0;
      lock_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dly_cnt  <= '0;
          hold_cnt <= '0;
          lock_cnt <= '0;
          if (sys_ready && lock_10) begin
            stage_en <= N_STAGES'(1);
            state    <= S_RAMP;
          end
        end
        S_RAMP, S_RUN: begin
          if (!sys_ready) begin
            stage_en <= '0;
            seq_done <= 1'b0;
            dly_cnt  <= '0;
            lock_cnt <= '0;
            state    <= S_IDLE;
          end else if (trip) begin
            // Trip beats a coincident stage step: nothing stays enabled.
            stage_en <= '0;
            seq_done <= 1'b0;
            fault    <= 1'b1;
            if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
            hold_cnt <= '0;
            lock_cnt <= '0;
            dly_cnt  <= '0;
            state    <= S_FAULT;
          end else begin
            lock_cnt <= lock_10 ? '0 : lock_cnt + 1'b1;
            if (state == S_RAMP) begin
              if (dly_cnt == DLY_LAST) begin
                dly_cnt <= '0;
                // All bits already up: this interval is the settle time.
                if (&stage_en) begin
                  seq_done <= 1'b1;
                  state    <= S_RUN;
                end else begin
                  stage_en <= stage_next;
                end
              end else begin
                dly_cnt <= dly_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          stage_en <= '0;
          if (hold_cnt == HOLD_LAST) begin
            fault    <= 1'b0;
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
